// File: rtl/nanov_shift_seq.sv
// nanov_shift_seq: bit-serial SLL/SRL/SRA sequencer for the nanoV execute stage.
// Emits one result bit per cycle (LSB first) and assembles the full result word.
module nanov_shift_seq #(
   parameter bit DONE_PULSE = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [4:0]  b,
   input  logic        abort,
   output logic        busy,
   output logic        bit_valid,
   output logic        bit_out,
   output logic [4:0]  bit_idx,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;
   localparam int unsigned PW = CW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   b_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   result_q;
   logic            right_q;
   logic            arith_q;
   logic            sign_q;

   logic            run_c;
   logic            accept_c;
   logic            neg_c;
   logic [CW-1:0]   b_x_c;
   logic [PW-1:0]   pos_c;
   logic            ovf_c;
   logic            fill_c;
   logic            raw_bit_c;
   logic            unused_c;

   // Position of the source bit for the current counter; MSB flags out-of-range.
   always_comb begin
      neg_c     = ~right_q;
      b_x_c     = b_q ^ {CW{neg_c}};
      pos_c     = {1'b0, cnt_q} + {neg_c, b_x_c} + PW'(neg_c);
      ovf_c     = pos_c[PW-1];
      fill_c    = arith_q & sign_q;
      raw_bit_c = 1'b0;
      if (right_q) begin
         raw_bit_c = ovf_c ? fill_c : a_q[b_q];
      end else begin
         raw_bit_c = ovf_c ? 1'b0 : a_q[0];
      end
   end

   // Only op[2] and op[3] select the operation; low opcode bits are don't-care.
   assign unused_c = ^{op[1:0], pos_c[PW-2:0]};

   assign run_c    = (state_q == RUN);
   assign accept_c = start & ~abort & ((state_q == IDLE) | (state_q == DONE));

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over everything, start is ignored while running.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept_c) state_d = RUN;
         end
         RUN: begin
            if (abort)                       state_d = IDLE;
            else if (cnt_q == CW'(DW - 1))   state_d = DONE;
         end
         DONE: begin
            if (abort)           state_d = IDLE;
            else if (accept_c)   state_d = RUN;
            else if (DONE_PULSE) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, serial stepping and result assembly.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q    <= '0;
         b_q      <= '0;
         a_q      <= '0;
         result_q <= '0;
         right_q  <= 1'b0;
         arith_q  <= 1'b0;
         sign_q   <= 1'b0;
      end else if (accept_c) begin
         cnt_q   <= '0;
         b_q     <= b;
         a_q     <= a;
         right_q <= op[2];
         arith_q <= op[3];
         sign_q  <= a[DW-1];
      end else if (run_c) begin
         if (abort) begin
            cnt_q <= '0;
         end else begin
            cnt_q    <= cnt_q + CW'(1);
            result_q <= {raw_bit_c, result_q[DW-1:1]};
            if (!ovf_c) a_q <= {1'b0, a_q[DW-1:1]};
         end
      end
   end

   // Outputs decode from registered state; serial outputs are quiet outside RUN.
   assign busy      = run_c;
   assign bit_valid = run_c;
   assign bit_out   = run_c & raw_bit_c;
   assign bit_idx   = run_c ? cnt_q : '0;
   assign done      = (state_q == DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_nanov_shift_seq.sv
// Scoreboard bench for nanov_shift_seq: stimulus pushes expected results,
// a monitor pops and compares whenever done is seen.
module tb_nanov_shift_seq;

   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SRA = 4'b1101;

   typedef struct {
      logic [31:0] res;
      int unsigned cyc;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        start, abort;
   logic [3:0]  op;
   logic [31:0] a;
   logic [4:0]  b;
   logic        busy, bit_valid, bit_out, done;
   logic [4:0]  bit_idx;
   logic [31:0] result;

   logic        start_h, abort_h;
   logic        busy_h, bit_valid_h, bit_out_h, done_h;
   logic [4:0]  bit_idx_h;
   logic [31:0] result_h;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   exp_t        sbq[$];

   nanov_shift_seq #(.DONE_PULSE(1'b1)) u_dut (
      .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .abort(abort),
      .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out), .bit_idx(bit_idx),
      .done(done), .result(result)
   );

   nanov_shift_seq #(.DONE_PULSE(1'b0)) u_dut_hold (
      .clk(clk), .rstn(rstn), .start(start_h), .op(op), .a(a), .b(b), .abort(abort_h),
      .busy(busy_h), .bit_valid(bit_valid_h), .bit_out(bit_out_h), .bit_idx(bit_idx_h),
      .done(done_h), .result(result_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to time done relative to the accepting edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   // Drive one request on the pulse-mode DUT; optionally register its expected result.
   // Done is due 32 edges after the accepting edge (the 33rd cycle after it).
   task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [4:0] bv,
                        input bit push, input logic [31:0] exp);
      @(negedge clk);
      op = o; a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (push) sbq.push_back('{exp, cyc + 32});
   endtask

   task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [4:0] bv,
                         input logic [31:0] exp);
      issue(o, av, bv, 1'b1, exp);
      repeat (33) @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: collect the serial stream, compare it and result against the scoreboard on done.
   initial begin
      logic [31:0] stream;
      int unsigned nbits;
      exp_t        e;
      stream = '0;
      nbits  = 0;
      forever begin
         @(posedge clk); #1;
         if (rstn) begin
            if (bit_valid) begin
               if (bit_idx == 5'd0) nbits = 0;
               stream[bit_idx] = bit_out;
               nbits++;
            end else begin
               check("idle_bit_out", 32'(bit_out), 32'd0);
               check("idle_bit_idx", 32'(bit_idx), 32'd0);
            end
            if (done) begin
               if (sbq.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", cyc);
               end else begin
                  e = sbq.pop_front();
                  check("result", result, e.res);
                  check("serial_stream", stream, e.res);
                  check("serial_bits", 32'(nbits), 32'd32);
                  check("done_edge", 32'(cyc), 32'(e.cyc));
               end
            end
         end
      end
   end

   initial begin
      rstn = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
      start_h = 1'b0; abort_h = 1'b0;
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bit_valid", 32'(bit_valid), 32'd0);
      check("rst_bit_out", 32'(bit_out), 32'd0);
      check("rst_bit_idx", 32'(bit_idx), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_hold_done", 32'(done_h), 32'd0);
      check("rst_hold_result", result_h, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      run_op(OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
      run_op(OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000);
      run_op(OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000);
      run_op(OP_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
      run_op(OP_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
      run_op(OP_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
      run_op(OP_SRA, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF);
      run_op(OP_SRA, 32'h4000_0000, 5'd31, 32'h0000_0000);
      run_op(OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001);
      run_op(OP_SLL, 32'h1234_5678, 5'd8,  32'h3456_7800);
      run_op(OP_SRA, 32'h1234_5678, 5'd8,  32'h0012_3456);
      run_op(OP_SRA, 32'hF234_5678, 5'd8,  32'hFFF2_3456);

      // Start while running is ignored; start during DONE is accepted back-to-back.
      issue(OP_SRL, 32'hF0F0_0000, 5'd12, 1'b1, 32'h000F_0F00);
      repeat (5) @(posedge clk);
      #1;
      check("run_idx5", 32'(bit_idx), 32'd5);
      @(negedge clk);
      op = OP_SLL; a = 32'hFFFF_FFFF; b = 5'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ignored_start_busy", 32'(busy), 32'd1);
      check("ignored_start_idx", 32'(bit_idx), 32'd6);
      wait_done();
      issue(OP_SLL, 32'h0000_00FF, 5'd4, 1'b1, 32'h0000_0FF0);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done();
      repeat (2) @(posedge clk);
      #1;

      // Abort at counter 10: straight to IDLE with no done.
      issue(OP_SLL, 32'h1234_5678, 5'd3, 1'b0, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_idx10", 32'(bit_idx), 32'd10);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_bit_valid", 32'(bit_valid), 32'd0);
      repeat (35) @(posedge clk);
      #1;
      run_op(OP_SRL, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF);

      // Asynchronous reset between edges in the middle of an operation.
      issue(OP_SRA, 32'h8000_0000, 5'd2, 1'b0, 32'd0);
      repeat (8) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_bit_valid", 32'(bit_valid), 32'd0);
      check("mid_rst_bit_out", 32'(bit_out), 32'd0);
      check("mid_rst_bit_idx", 32'(bit_idx), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_result", result, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);

      // Held-done build: done stays up until the next accepted start.
      @(negedge clk);
      op = OP_SRA; a = 32'hF000_0000; b = 5'd8; start_h = 1'b1;
      @(posedge clk); #1;
      start_h = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_h) seen = 1'b1;
         end
         check("hold_done_seen", 32'(seen), 32'd1);
      end
      check("hold_result", result_h, 32'hFFF0_0000);
      repeat (5) @(posedge clk);
      #1;
      check("hold_done_held", 32'(done_h), 32'd1);
      check("hold_result_stable", result_h, 32'hFFF0_0000);
      @(negedge clk);
      op = OP_SLL; a = 32'h0000_0001; b = 5'd1; start_h = 1'b1;
      @(posedge clk); #1;
      start_h = 1'b0;
      check("hold_done_cleared", 32'(done_h), 32'd0);
      check("hold_restart_busy", 32'(busy_h), 32'd1);
      @(negedge clk);
      abort_h = 1'b1;
      @(posedge clk); #1;
      abort_h = 1'b0;
      check("hold_abort_busy", 32'(busy_h), 32'd0);
      check("hold_abort_done", 32'(done_h), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

endmodule
